// File: rtl/spram_bwe_init.sv
// Single-port synchronous RAM: per-lane write mask, 1/2-cycle read latency, and a clear FSM that fills the array with INIT_VAL.
// Optional feature: define SPRAM_RANDOM_Q_EN to drive random Q while Q_VALID is low (simulation only).
module spram_bwe_init #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 1024,
  parameter int                    MASK_GRAN     = 8,
  parameter int                    OUT_REG       = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL      = '0,
  parameter                        RAM_STYLE_VAL = "block",
  localparam int                   AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                   NL            = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CEN,
  input  logic                  WEN,
  input  logic [NL-1:0]         BWEN,
  input  logic [AW-1:0]         A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  CLR,
  output logic                  READY,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VALID
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  state_t                state;
  logic [AW-1:0]         cnt;
  logic                  req_ok;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  q_valid;

  (* ram_style = RAM_STYLE_VAL *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  if ((DATA_WIDTH % MASK_GRAN) != 0 || RAM_STYLE_VAL == "") begin : g_bad_params
    $error("spram_bwe_init: DATA_WIDTH must be a multiple of MASK_GRAN and RAM_STYLE_VAL non-empty");
  end

  assign req_ok   = READY && !CEN;
  assign wr_ok    = req_ok && !WEN;
  assign rd_ok    = req_ok && WEN;
  assign in_range = ({1'b0, A} < DEPTH_W);
  assign rd_word  = in_range ? mem[A] : INIT_VAL;

  // Clear sequencer: INIT sweeps every address once, RUN serves requests until CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
      cnt   <= '0;
      READY <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (CLR) begin
            cnt <= '0;
          end else if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= ST_RUN;
            READY <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (CLR) begin
            cnt   <= '0;
            state <= ST_INIT;
            READY <= 1'b0;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_INIT;
          READY <= 1'b0;
        end
      endcase
    end
  end

  // The array has no reset; while INIT owns the port, user writes cannot reach it.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_ok && in_range) begin
      for (int i = 0; i < NL; i++) begin
        if (!BWEN[i]) begin
          mem[A][i*MASK_GRAN +: MASK_GRAN] <= D[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  if (OUT_REG == 0) begin : g_lat1
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        q_valid <= 1'b0;
        q_data  <= '0;
      end else begin
        q_valid <= rd_ok;
        if (rd_ok) begin
          q_data <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    // The extra stage only moves data forward on valid, so Q still holds between reads.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        q_valid  <= 1'b0;
        q_data   <= '0;
      end else begin
        s1_valid <= rd_ok;
        if (rd_ok) begin
          s1_data <= rd_word;
        end
        q_valid <= s1_valid;
        if (s1_valid) begin
          q_data <= s1_data;
        end
      end
    end
  end

  assign Q_VALID = q_valid;

`ifdef SPRAM_RANDOM_Q_EN
  logic [DATA_WIDTH-1:0] q_rand;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_rand <= '0;
    end else begin
      q_rand <= DATA_WIDTH'($unsigned($random));
    end
  end

  assign Q = q_valid ? q_data : q_rand;
`else
  assign Q = q_data;
`endif

endmodule

// File: tb/tb_spram_bwe_init.sv
// Scoreboard bench for spram_bwe_init: two instances (1-cycle/INIT 0 and 2-cycle/INIT 5A5A5A5A) share one random stimulus stream.
module tb_spram_bwe_init;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INIT0 = 32'h0;
  localparam logic [31:0] INIT1 = 32'h5A5A5A5A;

  logic        clk   = 1'b0;
  logic        rstN  = 1'b1;
  logic        cen   = 1'b1;
  logic        wen   = 1'b1;
  logic        clr   = 1'b0;
  logic [3:0]  bwen  = 4'hF;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] data  = 32'h0;

  logic        ready0, ready1, qValid0, qValid1;
  logic [31:0] q0, q1;

  typedef struct {
    logic [31:0] value;
    int          due;
  } rdExp_t;

  rdExp_t      expQ0[$];
  rdExp_t      expQ1[$];
  logic [31:0] modelMem0 [DEPTH];
  logic [31:0] modelMem1 [DEPTH];
  logic [31:0] lastQ0 = 32'h0;
  logic [31:0] lastQ1 = 32'h0;
  int          initRemaining = DEPTH;
  bit          expReady = 1'b0;
  bit          inReset = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  spram_bwe_init #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .MASK_GRAN(8), .OUT_REG(0), .INIT_VAL(INIT0), .RAM_STYLE_VAL("block")
  ) dut0 (
    .CLK(clk), .RST_N(rstN), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(addr), .D(data), .CLR(clr),
    .READY(ready0), .Q(q0), .Q_VALID(qValid0)
  );

  spram_bwe_init #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .MASK_GRAN(8), .OUT_REG(1), .INIT_VAL(INIT1), .RAM_STYLE_VAL("block")
  ) dut1 (
    .CLK(clk), .RST_N(rstN), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(addr), .D(data), .CLR(clr),
    .READY(ready1), .Q(q1), .Q_VALID(qValid1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fillModel();
    for (int i = 0; i < DEPTH; i++) begin
      modelMem0[i] = INIT0;
      modelMem1[i] = INIT1;
    end
  endtask

  // Effect of the coming rising edge on the reference model.
  task automatic modelStep();
    bit accepted;
    accepted = (initRemaining == 0) && !cen;
    if (accepted && !wen) begin
      for (int l = 0; l < 4; l++) begin
        if (!bwen[l]) begin
          modelMem0[addr][l*8 +: 8] = data[l*8 +: 8];
          modelMem1[addr][l*8 +: 8] = data[l*8 +: 8];
        end
      end
    end
    if (accepted && wen) begin
      expQ0.push_back('{modelMem0[addr], cyc + 1});
      expQ1.push_back('{modelMem1[addr], cyc + 2});
    end
    if (clr) begin
      initRemaining = DEPTH;
      fillModel();
    end else if (initRemaining > 0) begin
      initRemaining--;
    end
    expReady = (initRemaining == 0);
  endtask

  task automatic applyStimulus(input bit c, input bit w, input logic [3:0] b, input logic [3:0] a,
                               input logic [31:0] d, input bit cl);
    @(negedge clk);
    cen  = c;
    wen  = w;
    bwen = b;
    addr = a;
    data = d;
    clr  = cl;
    modelStep();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic waitReady();
    int guard;
    guard = 0;
    while (!expReady && guard < 64) begin
      idle(1);
      guard++;
    end
    checkOutput("wait_ready_model", {31'b0, expReady}, 32'h1);
  endtask

  task automatic readSweep();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 4'hF, 4'(a), 32'h0, 1'b0);
    end
    idle(3);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN    = 1'b0;
    inReset = 1'b1;
    #1;
    checkOutput("rst_q0", q0, 32'h0);
    checkOutput("rst_qvalid0", {31'b0, qValid0}, 32'h0);
    checkOutput("rst_ready0", {31'b0, ready0}, 32'h0);
    checkOutput("rst_q1", q1, 32'h0);
    checkOutput("rst_qvalid1", {31'b0, qValid1}, 32'h0);
    checkOutput("rst_ready1", {31'b0, ready1}, 32'h0);
    expQ0.delete();
    expQ1.delete();
    lastQ0 = 32'h0;
    lastQ1 = 32'h0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    cen  = 1'b1;
    wen  = 1'b1;
    bwen = 4'hF;
    clr  = 1'b0;
    initRemaining = DEPTH;
    fillModel();
    inReset = 1'b0;
    modelStep();
  endtask

  // Monitor: pops the scoreboard on Q_VALID; otherwise Q must hold the previous read.
  task automatic monitorDut(input int k, input logic rdy, input logic qv, input logic [31:0] q);
    rdExp_t e;
    int     pending;
    checkOutput($sformatf("ready%0d", k), {31'b0, rdy}, {31'b0, expReady});
    pending = (k == 0) ? expQ0.size() : expQ1.size();
    if (qv === 1'b1) begin
      if (pending == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_qvalid%0d actual=1 expected=0 cycle=%0d", k, cyc);
      end else begin
        if (k == 0) e = expQ0.pop_front();
        else        e = expQ1.pop_front();
        checkOutput($sformatf("latency%0d", k), cyc, e.due);
        checkOutput($sformatf("qdata%0d", k), q, e.value);
        if (k == 0) lastQ0 = e.value;
        else        lastQ1 = e.value;
      end
    end else begin
      checkOutput($sformatf("qvalid%0d", k), {31'b0, qv}, 32'h0);
      checkOutput($sformatf("hold%0d", k), q, (k == 0) ? lastQ0 : lastQ1);
      if (pending != 0) begin
        e = (k == 0) ? expQ0[0] : expQ1[0];
        if (e.due <= cyc) begin
          checks++;
          failures++;
          $display("[TB] FAIL missing_qvalid%0d actual=0 expected=1 cycle=%0d", k, cyc);
          if (k == 0) void'(expQ0.pop_front());
          else        void'(expQ1.pop_front());
        end
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!inReset) begin
      monitorDut(0, ready0, qValid0, q0);
      monitorDut(1, ready1, qValid1, q1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fillModel();
    doReset();
    waitReady();
    readSweep();

    // Lane mask merge and read-after-write.
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'd3, 32'hAABBCCDD, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1010, 4'd3, 32'h11223344, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF,    4'd3, 32'h0,        1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'd5, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF,    4'd5, 32'h0,        1'b0);
    idle(2);

    // Back-to-back reads then a long idle stretch with a no-op write in it.
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd2, 32'h0, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 4'hF, 4'd2, 32'hFFFFFFFF, 1'b0);
    idle(6);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd2, 32'h0, 1'b0);
    idle(3);

    // Read issued together with CLR, then requests that must be dropped during INIT.
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd3, 32'h0, 1'b1);
    while (!expReady) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom, 1'b0);
    end
    readSweep();

    // Random traffic with occasional CLR.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    $urandom, $urandom_range(0, 63) == 0);
    end
    idle(3);
    waitReady();

    // Reset in the middle of a clear sweep.
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd9, 32'h12345678, 1'b1);
    idle(7);
    doReset();
    waitReady();
    readSweep();
    for (int n = 0; n < 100; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    $urandom, 1'b0);
    end
    idle(4);

    checkOutput("drain0", expQ0.size(), 32'h0);
    checkOutput("drain1", expQ1.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
